// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, one-entry skid buffer and synchronous flush.
// Latency: one cycle from accept to out_valid/out_data when the stage is empty or emitting.
// Backpressure: in_ready is registered (= skid empty); a beat landing during a stall parks in the skid.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   flush                synchronous clear of all held beats (below rst_n in priority)
//   in_valid/in_ready    upstream handshake, in_data payload
//   out_valid/out_ready  downstream handshake, out_data payload (registered)
//   stall_cnt, skid_hits saturating statistics, present only when PIPE_SKID_STATS_EN is defined
module pipe_skid_reg #(
  parameter int unsigned           WIDTH       = 32,
  parameter logic [WIDTH-1:0]      RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef PIPE_SKID_STATS_EN
  output logic [31:0]      stall_cnt,
  output logic [31:0]      skid_hits,
`endif
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // main empty, skid empty
    ONE   = 2'd1,  // main full,  skid empty
    FULL  = 2'd2   // main full,  skid full
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q,  main_d;
  logic [WIDTH-1:0] skid_q,  skid_d;
  logic             accept;
  logic             emit;
  logic             skid_fill;

  // Both handshake flags are decoded from the state register only, so
  // neither has a combinational path from the opposite side.
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL);
  assign out_data  = main_q;

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    main_d    = main_q;
    skid_d    = skid_q;
    skid_fill = 1'b0;

    if (flush) begin
      // Any beat accepted or still held this cycle is dropped; a beat
      // emitted this cycle has already been taken downstream.
      state_d = EMPTY;
      main_d  = RESET_VALUE;
      skid_d  = RESET_VALUE;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (accept && emit) begin
            main_d = in_data;
          end else if (accept) begin
            // Downstream stalled while upstream still had a beat in flight:
            // park it in the skid and drop in_ready next cycle.
            state_d   = FULL;
            skid_d    = in_data;
            skid_fill = 1'b1;
          end else if (emit) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so no accept can occur.
          if (emit) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= RESET_VALUE;
      skid_q  <= RESET_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_SKID_STATS_EN
  // Counters survive flush; only rst_n clears them. Both saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 32'd0;
      skid_hits <= 32'd0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (skid_fill && (skid_hits != 32'hFFFF_FFFF)) begin
        skid_hits <= skid_hits + 32'd1;
      end
    end
  end
`else
  // skid_fill only feeds the statistics counters.
  logic unused_skid_fill;
  assign unused_skid_fill = skid_fill;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: reset, streaming, skid fill/drain,
// flush, asynchronous reset and (when PIPE_SKID_STATS_EN is defined) the counters.
module tb_pipe_skid_reg;

  localparam int unsigned      W  = 16;
  localparam logic [W-1:0]     RV = 16'h5A5A;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
`ifdef PIPE_SKID_STATS_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   skid_hits;
`endif

  int checks = 0;
  int errors = 0;

  pipe_skid_reg #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef PIPE_SKID_STATS_EN
    .stall_cnt (stall_cnt),
    .skid_hits (skid_hits),
`endif
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset held for 3 cycles
    repeat (3) tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  {16'd0, out_data},  {16'd0, RV});
    rst_n = 1'b1;
    tick();
    chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_out_data",  {16'd0, out_data},  {16'd0, RV});
    chk("idle_in_ready",  {31'd0, in_ready},  32'd1);

    // Streaming 1,2,3 with downstream always ready
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h0001; tick();
    chk("str1_valid", {31'd0, out_valid}, 32'd1);
    chk("str1_data",  {16'd0, out_data},  32'h1);
    chk("str1_ready", {31'd0, in_ready},  32'd1);
    in_data   = 16'h0002; tick();
    chk("str2_data",  {16'd0, out_data},  32'h2);
    chk("str2_ready", {31'd0, in_ready},  32'd1);
    in_data   = 16'h0003; tick();
    chk("str3_data",  {16'd0, out_data},  32'h3);
    chk("str3_valid", {31'd0, out_valid}, 32'd1);
    in_valid  = 1'b0; tick();
    chk("str_drain_valid", {31'd0, out_valid}, 32'd0);

    // Skid fill: A then B with downstream stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h000A; tick();
    chk("skA_data",  {16'd0, out_data}, 32'hA);
    chk("skA_ready", {31'd0, in_ready}, 32'd1);
    in_data   = 16'h000B; tick();
    chk("skB_data",  {16'd0, out_data}, 32'hA);
    chk("skB_ready", {31'd0, in_ready}, 32'd0);
    in_data   = 16'h000C; tick();   // refused: in_ready is low
    chk("skC_hold_data",  {16'd0, out_data}, 32'hA);
    chk("skC_hold_ready", {31'd0, in_ready}, 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1; tick();       // A delivered, B moves to main
    chk("dr1_data",  {16'd0, out_data},  32'hB);
    chk("dr1_valid", {31'd0, out_valid}, 32'd1);
    chk("dr1_ready", {31'd0, in_ready},  32'd1);
    tick();                          // B delivered
    chk("dr2_valid", {31'd0, out_valid}, 32'd0);

    // Flush while FULL with a beat offered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h000A; tick();
    in_data   = 16'h000B; tick();
    chk("fl_full_ready", {31'd0, in_ready}, 32'd0);
    in_data   = 16'h000C;
    flush     = 1'b1; tick();
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_data",  {16'd0, out_data},  {16'd0, RV});
    chk("fl_ready", {31'd0, in_ready},  32'd1);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1; tick();
    chk("fl_noC_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_noC_data",  {16'd0, out_data},  {16'd0, RV});

    // Flush in ONE while a new beat is accepted: the new beat is discarded
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h000D; tick();
    chk("fl1_d_data", {16'd0, out_data}, 32'hD);
    in_data   = 16'h000E;
    flush     = 1'b1; tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    chk("fl1_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("fl1_noE_valid", {31'd0, out_valid}, 32'd0);
    chk("fl1_noE_data",  {16'd0, out_data},  {16'd0, RV});

    // Asynchronous reset between edges while a beat is held
    in_valid  = 1'b1;
    in_data   = 16'h0007; tick();
    in_valid  = 1'b0;
    chk("ar_pre_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_data",  {16'd0, out_data},  {16'd0, RV});
    #1;
    rst_n = 1'b1;
    tick();
    chk("ar_post_ready", {31'd0, in_ready},  32'd1);
    chk("ar_post_valid", {31'd0, out_valid}, 32'd0);

`ifdef PIPE_SKID_STATS_EN
    chk("st_rst_stall", stall_cnt, 32'd0);
    chk("st_rst_hits",  skid_hits, 32'd0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0001; tick();   // enters ONE; stall not yet counted
    in_valid  = 1'b0;
    chk("st_load_stall", stall_cnt, 32'd0);
    repeat (5) tick();
    chk("st_stall5", stall_cnt, 32'd5);
    chk("st_hits0",  skid_hits, 32'd0);
    in_valid  = 1'b1;
    in_data   = 16'h0002; tick();   // ONE -> FULL, still stalled
    in_valid  = 1'b0;
    chk("st_stall6", stall_cnt, 32'd6);
    chk("st_hits1",  skid_hits, 32'd1);
    out_ready = 1'b1;
    flush     = 1'b1; tick();       // flush with emit: no stall, no skid fill
    flush     = 1'b0;
    chk("st_fl_stall", stall_cnt, 32'd6);
    chk("st_fl_hits",  skid_hits, 32'd1);
    chk("st_fl_valid", {31'd0, out_valid}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
